// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C sequencer: expands one START / byte / ACK / STOP command into PHY bit strobes.
// Optional PHY-op watchdog and sticky timeout output: define I2C_BYTE_CTRL_TIMEOUT_EN.
module i2c_byte_ctrl #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_write,
    input  logic       cmd_read,
    input  logic       cmd_stop,
    input  logic       cmd_nack,
    input  logic [7:0] tx_byte,
    input  logic       abort,
    output logic [7:0] rx_byte,
    output logic       rx_nack,
    output logic       done,
    output logic       cmd_err,
    output logic       busy,
    output logic       phy_start_bit,
    output logic       phy_stop_bit,
    output logic       phy_write_bit,
    output logic       phy_read_bit,
    output logic       phy_tx_data,
    output logic       phy_release_bus,
    input  logic [4:0] phy_state,
    input  logic       phy_bus_control,
    input  logic       phy_rx_data
`ifdef I2C_BYTE_CTRL_TIMEOUT_EN
    ,
    output logic       timeout
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_BYTE, S_ACK, S_STOP, S_DONE} state_t;

    state_t     state_q;
    logic       issue_q;
    logic [2:0] bit_q;
    logic       start_q, write_q, read_q, stop_q, nack_q;
    logic [7:0] tx_q, rx_q;
    logic       rx_nack_q, done_q, err_q, rel_q;
    logic       st_q, sp_q, wr_q, rd_q, txd_q;

    logic       idle, op_state, phy_idle, op_done, illegal, tmo_hit, abort_all;
    logic       wflag, tst_d, tsp_d, twr_d, trd_d, txd_d;
    logic [2:0] idx_d;
    logic [7:0] byte_src;
    state_t     first_d, next_d, target_d;

    assign idle      = (state_q == S_IDLE);
    assign op_state  = (state_q == S_START) || (state_q == S_BYTE) ||
                       (state_q == S_ACK)   || (state_q == S_STOP);
    assign phy_idle  = (phy_state == 5'd0) || (phy_state == 5'd1);
    assign cmd_ready = idle & ~abort;
    assign abort_all = abort | tmo_hit;

    assign illegal = (cmd_write & cmd_read) |
                     ((cmd_write | cmd_read) & ~cmd_start & ~phy_bus_control) |
                     ~(cmd_start | cmd_write | cmd_read | cmd_stop);

    // WAIT completion: START must land in ACTIVE, STOP in IDLE, bit ops in either
    always_comb begin
        op_done = 1'b0;
        if (!issue_q) begin
            case (state_q)
                S_START: op_done = (phy_state == 5'd1);
                S_STOP:  op_done = (phy_state == 5'd0);
                S_BYTE,
                S_ACK:   op_done = phy_idle;
                default: op_done = 1'b0;
            endcase
        end
    end

    always_comb begin
        if (illegal)                           first_d = S_DONE;
        else if (cmd_start)                    first_d = S_START;
        else if (cmd_write | cmd_read)         first_d = S_BYTE;
        else if (cmd_stop & phy_bus_control)   first_d = S_STOP;
        else                                   first_d = S_DONE;

        case (state_q)
            S_START: next_d = (write_q | read_q) ? S_BYTE : (stop_q ? S_STOP : S_DONE);
            S_BYTE:  next_d = (bit_q == 3'd0) ? S_ACK : S_BYTE;
            S_ACK:   next_d = stop_q ? S_STOP : S_DONE;
            default: next_d = S_DONE;
        endcase

        target_d = idle ? first_d : next_d;
        wflag    = idle ? cmd_write : write_q;
        byte_src = idle ? tx_byte : tx_q;
        idx_d    = (state_q == S_BYTE) ? bit_q - 3'd1 : 3'd7;

        tst_d = (target_d == S_START);
        tsp_d = (target_d == S_STOP);
        twr_d = ((target_d == S_BYTE) & wflag) | ((target_d == S_ACK) & ~wflag);
        trd_d = ((target_d == S_BYTE) & ~wflag) | ((target_d == S_ACK) & wflag);
        txd_d = (target_d == S_BYTE) ? byte_src[idx_d] : nack_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            issue_q   <= 1'b0;
            bit_q     <= 3'd7;
            start_q   <= 1'b0;
            write_q   <= 1'b0;
            read_q    <= 1'b0;
            stop_q    <= 1'b0;
            nack_q    <= 1'b0;
            tx_q      <= 8'h00;
            rx_q      <= 8'h00;
            rx_nack_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rel_q     <= 1'b0;
            st_q      <= 1'b0;
            sp_q      <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            txd_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            rel_q  <= 1'b0;
            if (abort_all) begin
                rel_q <= 1'b1;
                st_q  <= 1'b0;
                sp_q  <= 1'b0;
                wr_q  <= 1'b0;
                rd_q  <= 1'b0;
                if (op_state) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    err_q   <= 1'b1;
                end else begin
                    state_q <= S_IDLE;
                end
            end else begin
                case (state_q)
                    S_IDLE: if (cmd_valid) begin
                        start_q <= cmd_start;
                        write_q <= cmd_write;
                        read_q  <= cmd_read;
                        stop_q  <= cmd_stop;
                        nack_q  <= cmd_nack;
                        tx_q    <= tx_byte;
                        bit_q   <= 3'd7;
                        issue_q <= 1'b1;
                        state_q <= target_d;
                        st_q    <= tst_d;
                        sp_q    <= tsp_d;
                        wr_q    <= twr_d;
                        rd_q    <= trd_d;
                        txd_q   <= txd_d;
                        if (target_d == S_DONE) begin
                            done_q <= 1'b1;
                            err_q  <= illegal;
                        end
                    end
                    S_START, S_BYTE, S_ACK, S_STOP: begin
                        if (issue_q) begin
                            // PHY has picked the strobe up once it leaves IDLE/ACTIVE
                            if (!phy_idle) begin
                                issue_q <= 1'b0;
                                st_q    <= 1'b0;
                                sp_q    <= 1'b0;
                                wr_q    <= 1'b0;
                                rd_q    <= 1'b0;
                            end
                        end else if (op_done) begin
                            if (state_q == S_BYTE) begin
                                bit_q <= bit_q - 3'd1;
                                if (read_q)
                                    rx_q <= {rx_q[6:0], phy_rx_data};
                            end
                            if ((state_q == S_ACK) && write_q)
                                rx_nack_q <= phy_rx_data;
                            issue_q <= 1'b1;
                            state_q <= target_d;
                            st_q    <= tst_d;
                            sp_q    <= tsp_d;
                            wr_q    <= twr_d;
                            rd_q    <= trd_d;
                            txd_q   <= txd_d;
                            if (target_d == S_DONE)
                                done_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

`ifdef I2C_BYTE_CTRL_TIMEOUT_EN
    logic [19:0] wdog_q;
    logic        timeout_q;

    assign tmo_hit = op_state & (wdog_q == TIMEOUT_CYCLES);
    assign timeout = timeout_q;

    // Restarts at each new ISSUE so the limit applies per bit operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q    <= 20'd0;
            timeout_q <= 1'b0;
        end else begin
            if (!op_state || op_done)
                wdog_q <= 20'd0;
            else
                wdog_q <= wdog_q + 20'd1;
            if (cmd_valid && cmd_ready)
                timeout_q <= 1'b0;
            else if (tmo_hit)
                timeout_q <= 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^{TIMEOUT_CYCLES, start_q};
`endif

    assign rx_byte         = rx_q;
    assign rx_nack         = rx_nack_q;
    assign done            = done_q;
    assign cmd_err         = err_q;
    assign busy            = ~idle;
    assign phy_start_bit   = st_q;
    assign phy_stop_bit    = sp_q;
    assign phy_write_bit   = wr_q;
    assign phy_read_bit    = rd_q;
    assign phy_tx_data     = txd_q;
    assign phy_release_bus = rel_q;

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Scoreboard bench for i2c_byte_ctrl: behavioural PHY logs every accepted bit op, monitor checks each done.
module tb_i2c_byte_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       cmd_valid = 0, cmd_start = 0, cmd_write = 0, cmd_read = 0, cmd_stop = 0, cmd_nack = 0;
    logic [7:0] tx_byte = 8'h00;
    logic       abort = 0;
    logic       cmd_ready, rx_nack, done, cmd_err, busy;
    logic [7:0] rx_byte;
    logic       phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit, phy_tx_data, phy_release_bus;
    logic [4:0] phy_state;
    logic       phy_bus_control, phy_rx_data;

    i2c_byte_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_read(cmd_read),
        .cmd_stop(cmd_stop), .cmd_nack(cmd_nack), .tx_byte(tx_byte), .abort(abort),
        .rx_byte(rx_byte), .rx_nack(rx_nack), .done(done), .cmd_err(cmd_err), .busy(busy),
        .phy_start_bit(phy_start_bit), .phy_stop_bit(phy_stop_bit),
        .phy_write_bit(phy_write_bit), .phy_read_bit(phy_read_bit),
        .phy_tx_data(phy_tx_data), .phy_release_bus(phy_release_bus),
        .phy_state(phy_state), .phy_bus_control(phy_bus_control), .phy_rx_data(phy_rx_data)
    );

    // PHY model: S=START from idle, r=repeated START, P=STOP, 1/0=written bit, R=read bit
    string ops = "";
    logic  slave_bits[$];
    int    pcnt;
    logic [4:0] pend_state;
    logic  pend_bus;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phy_state <= 5'd0; phy_bus_control <= 1'b0; phy_rx_data <= 1'b1; pcnt <= 0;
            pend_state <= 5'd0; pend_bus <= 1'b0;
        end else if (phy_release_bus) begin
            phy_state <= 5'd0; phy_bus_control <= 1'b0; pcnt <= 0;
        end else if (phy_state > 5'd1) begin
            if (pcnt == 0) begin
                phy_state <= pend_state; phy_bus_control <= pend_bus;
            end else begin
                pcnt <= pcnt - 1;
            end
        end else if (phy_start_bit | phy_stop_bit | phy_write_bit | phy_read_bit) begin
            pcnt <= 3; pend_state <= phy_state; pend_bus <= phy_bus_control;
            if (phy_start_bit) begin
                phy_state <= 5'd3; pend_state <= 5'd1; pend_bus <= 1'b1;
                if (phy_state == 5'd1) ops <= {ops, "r"}; else ops <= {ops, "S"};
            end else if (phy_stop_bit) begin
                phy_state <= 5'd4; pend_state <= 5'd0; pend_bus <= 1'b0;
                ops <= {ops, "P"};
            end else if (phy_write_bit) begin
                phy_state <= 5'd5;
                if (phy_tx_data) ops <= {ops, "1"}; else ops <= {ops, "0"};
            end else begin
                phy_state <= 5'd6;
                ops <= {ops, "R"};
                if (slave_bits.size() != 0) phy_rx_data <= slave_bits.pop_front();
                else phy_rx_data <= 1'b1;
            end
        end
    end

    typedef struct {
        int    err;
        string ops;
        int    rx;    // -1 = don't care
        int    nack;
        int    bus;
        int    pst;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ops_pos = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    // Monitor: each done pulse retires the oldest expected command
    always @(negedge clk) begin
        exp_t  e;
        string g;
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
            end else begin
                e = sb.pop_front();
                g = ops.substr(ops_pos, ops.len() - 1);
                ops_pos = ops.len();
                chk("cmd_err", int'(cmd_err), e.err);
                checks++;
                if (g != e.ops) begin
                    errors++;
                    $display("FAIL phy_ops: got \"%s\", expected \"%s\"", g, e.ops);
                end
                if (e.rx   >= 0) chk("rx_byte", int'(rx_byte), e.rx);
                if (e.nack >= 0) chk("rx_nack", int'(rx_nack), e.nack);
                if (e.bus  >= 0) chk("bus_control", int'(phy_bus_control), e.bus);
                if (e.pst  >= 0) chk("phy_state", int'(phy_state), e.pst);
            end
        end
    end

    task automatic send(input logic s, w, r, p, n, input logic [7:0] b,
                        input int e_err, input string e_ops,
                        input int e_rx, input int e_nack, input int e_bus, input int e_pst);
        exp_t x;
        int   k;
        x.err = e_err; x.ops = e_ops; x.rx = e_rx; x.nack = e_nack; x.bus = e_bus; x.pst = e_pst;
        sb.push_back(x);
        k = 0;
        while (cmd_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        cmd_valid = 1; cmd_start = s; cmd_write = w; cmd_read = r; cmd_stop = p; cmd_nack = n; tx_byte = b;
        @(negedge clk);
        cmd_valid = 0; cmd_start = 0; cmd_write = 0; cmd_read = 0; cmd_stop = 0; cmd_nack = 0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 3000) begin @(negedge clk); k++; end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d commands without done, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int k, base;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cmd_err", int'(cmd_err), 0);
        chk("rst_rx_byte", int'(rx_byte), 0);
        chk("rst_rx_nack", int'(rx_nack), 0);
        chk("rst_strobes", int'({phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit}), 0);
        chk("rst_release", int'(phy_release_bus), 0);
        rst = 0;
        @(negedge clk);

        slave_bits.push_back(1'b0);
        send(1, 1, 0, 0, 0, 8'hA5, 0, "S10100101R", 0, 0, 1, -1);
        drain();

        slave_bits = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        send(0, 0, 1, 1, 1, 8'h00, 0, "RRRRRRRR1P", 8'h3C, 0, 0, 0);
        drain();

        slave_bits.push_back(1'b0);
        send(1, 1, 0, 0, 0, 8'h50, 0, "S01010000R", 8'h3C, 0, 1, -1);
        drain();
        slave_bits = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        send(1, 0, 1, 0, 0, 8'h00, 0, "rRRRRRRRR0", 8'h81, 0, 1, -1);
        drain();
        slave_bits.push_back(1'b1);
        send(1, 1, 0, 1, 0, 8'hFF, 0, "r11111111RP", 8'h81, 1, 0, 0);
        drain();

        send(1, 1, 1, 0, 0, 8'h00, 1, "", 8'h81, 1, 0, 0);
        drain();
        send(0, 1, 0, 0, 0, 8'h12, 1, "", 8'h81, 1, 0, 0);
        drain();
        send(0, 0, 0, 0, 0, 8'h00, 1, "", -1, -1, 0, 0);
        drain();
        send(0, 0, 0, 1, 0, 8'h00, 0, "", -1, -1, 0, 0);
        drain();

        base = ops.len();
        send(1, 1, 0, 0, 0, 8'hA5, 1, "S1010", 8'h81, 1, -1, -1);
        k = 0;
        while (ops.len() < base + 5 && k < 500) begin @(negedge clk); k++; end
        chk("abort_busy", int'(busy), 1);
        chk("abort_ready_low", int'(cmd_ready), 0);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_release", int'(phy_release_bus), 1);
        chk("abort_strobes", int'({phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit}), 0);
        @(negedge clk);
        chk("abort_ready_next", int'(cmd_ready), 1);
        chk("abort_release_1cyc", int'(phy_release_bus), 0);
        chk("abort_bus_freed", int'(phy_bus_control), 0);
        drain();

        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("idle_abort_release", int'(phy_release_bus), 1);
        chk("idle_abort_no_done", int'(done), 0);
        chk("idle_abort_busy", int'(busy), 0);
        repeat (3) @(negedge clk);

        send(1, 0, 0, 1, 0, 8'h00, 0, "SP", 8'h81, 1, 0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
